// File: rtl/ex_muldiv_seq_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_seq_if
//   Handshake bundle between the EX stage and the iterative RV32M sequencer.
//   master : EX-stage side (drives the op, observes stall/done/result)
//   slave  : the sequencer
// Signals
//   start   EX holds a valid M-extension op
//   funct3  M op select (0 MUL .. 7 REMU)
//   rs1     forwarded rs1 (dividend / multiplicand)
//   rs2     forwarded rs2 (divisor / multiplier)
//   flush   kill of the EX instruction; aborts the op
//   stall   hold PC, IF/ID, ID/EX
//   done    result valid this cycle
//   result  product / quotient / remainder
// ----------------------------------------------------------------------------
interface ex_muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] rs1;
   logic [WIDTH-1:0] rs2;
   logic             flush;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, funct3, rs1, rs2, flush,
      input  stall, done, result
   );

   modport slave (
      input  start, funct3, rs1, rs2, flush,
      output stall, done, result
   );
endinterface

// File: rtl/ex_muldiv_seq.sv
// ----------------------------------------------------------------------------
// ex_muldiv_seq
//   Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
//   Radix-2 shift-add multiply or restoring divide on operand magnitudes over
//   WIDTH cycles, then a sign fix-up. Divide-by-zero and signed overflow are
//   resolved straight from IDLE without iterating.
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   io_md  slave side of ex_muldiv_seq_if (start/funct3/rs1/rs2/flush in,
//          stall/done/result out)
// ----------------------------------------------------------------------------
module ex_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst,
   ex_muldiv_seq_if.slave  io_md
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_funct3;
   logic [WIDTH-1:0]   r_a;        // |multiplicand| for MUL ops
   logic [WIDTH-1:0]   r_b;        // |divisor| for DIV ops
   logic               r_neg_res;  // negate product / quotient
   logic               r_neg_rem;  // remainder takes dividend sign
   logic [2*WIDTH-1:0] r_acc;      // MUL: {hi, multiplier}  DIV: {rem, dividend/quotient}
   logic [WIDTH-1:0]   r_result;

   logic w_stall;
   logic w_done;

   // ---------------------------------------------------------------------
   // Operand decode, used only while accepting in IDLE
   // ---------------------------------------------------------------------
   logic [2:0]       w_f;
   logic             w_s1_signed, w_s2_signed;
   logic             w_neg1, w_neg2;
   logic [WIDTH-1:0] w_abs1, w_abs2;
   logic             w_div0, w_ovf, w_special;
   logic [WIDTH-1:0] w_special_res;
   logic             w_accept;

   assign w_f         = io_md.funct3;
   // MUL is treated as signed; its low half is identical either way.
   assign w_s1_signed = (w_f == 3'd0) || (w_f == 3'd1) || (w_f == 3'd2) ||
                        (w_f == 3'd4) || (w_f == 3'd6);
   assign w_s2_signed = (w_f == 3'd0) || (w_f == 3'd1) ||
                        (w_f == 3'd4) || (w_f == 3'd6);
   assign w_neg1      = w_s1_signed && io_md.rs1[WIDTH-1];
   assign w_neg2      = w_s2_signed && io_md.rs2[WIDTH-1];
   assign w_abs1      = w_neg1 ? -io_md.rs1 : io_md.rs1;
   assign w_abs2      = w_neg2 ? -io_md.rs2 : io_md.rs2;

   assign w_div0      = (io_md.rs2 == '0);
   assign w_ovf       = !w_f[0] && (io_md.rs1 == MIN_NEG) && (io_md.rs2 == '1);
   assign w_special   = w_f[2] && (w_div0 || w_ovf);
   // funct3[1] selects remainder (REM/REMU) over quotient (DIV/DIVU).
   assign w_special_res = w_div0 ? (w_f[1] ? io_md.rs1 : '1)
                                 : (w_f[1] ? '0 : MIN_NEG);

   assign w_accept    = (r_state == S_IDLE) && io_md.start && !io_md.flush;

   // ---------------------------------------------------------------------
   // One iteration of the datapath
   // ---------------------------------------------------------------------
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_div_upper;
   logic [WIDTH-1:0]   w_div_diff;
   logic               w_div_ge;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_iter;
   logic               w_last;

   // Add the multiplicand into the high half when the multiplier LSB is set,
   // then shift the whole accumulator (with the carry) right by one.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Shift the next dividend bit into the partial remainder; the remainder
   // stays below the divisor, so the difference always fits in WIDTH bits.
   assign w_div_upper = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_div_ge    = (w_div_upper >= {1'b0, r_b});
   assign w_div_diff  = w_div_upper[WIDTH-1:0] - r_b;
   assign w_div_next  = w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                                 : {w_div_upper[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

   assign w_iter = r_funct3[2] ? w_div_next : w_mul_next;
   assign w_last = (r_cnt == '0);

   // Sign fix-up applied to the final iteration
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo, w_rem;
   logic [WIDTH-1:0]   w_final;

   assign w_prod = r_neg_res ? -w_mul_next : w_mul_next;
   assign w_quo  = w_div_next[WIDTH-1:0];
   assign w_rem  = w_div_next[2*WIDTH-1:WIDTH];

   always_comb begin
      w_final = w_prod[WIDTH-1:0];
      if (r_funct3[2]) begin
         if (r_funct3[1]) w_final = r_neg_rem ? -w_rem : w_rem;
         else             w_final = r_neg_res ? -w_quo : w_quo;
      end else if (r_funct3 != 3'd0) begin
         w_final = w_prod[2*WIDTH-1:WIDTH];
      end
   end

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so that no
      // path leaves it unassigned, which would infer a latch.
      w_next  = r_state;
      w_stall = 1'b0;
      w_done  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (io_md.start && !io_md.flush) begin
               w_stall = 1'b1;
               w_next  = w_special ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (io_md.flush) begin
               w_next = S_IDLE;
            end else begin
               w_stall = 1'b1;
               if (w_last) w_next = S_DONE;
            end
         end
         S_DONE: begin
            // start here is the retiring instruction itself and is ignored.
            w_next = S_IDLE;
            w_done = !io_md.flush;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Gated with rst so a pending start cannot hold the pipeline during reset.
   assign io_md.stall  = w_stall && !rst;
   assign io_md.done   = w_done && !rst;
   assign io_md.result = r_result;

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_funct3  <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_acc     <= '0;
         r_result  <= '0;
      end else if (w_accept) begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         r_funct3  <= w_f;
         r_a       <= w_abs1;
         r_b       <= w_abs2;
         r_neg_res <= w_neg1 ^ w_neg2;
         r_neg_rem <= w_neg1;
         r_cnt     <= CNT_W'(WIDTH - 1);
         r_acc     <= w_f[2] ? {{WIDTH{1'b0}}, w_abs1} : {{WIDTH{1'b0}}, w_abs2};
         if (w_special) r_result <= w_special_res;
      end else if (r_state == S_CALC && !io_md.flush) begin
         r_acc <= w_iter;
         r_cnt <= r_cnt - CNT_W'(1);
         if (w_last) r_result <= w_final;
      end
   end

endmodule
